// File: rtl/led_line_sched_if.sv
// Bundle between the line scheduler, the pixel FIFO, the column shifter and the LED panel controls.
// LED_SCHED_UNDERFLOW_CNT_EN adds the underflow_cnt status word to the bundle.
interface led_line_sched_if;
   logic        en;
   logic [11:0] fifo_dout;
   logic        fifo_valid;
   logic        fifo_re;
   logic [11:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        line_start;
   logic        latch;
   logic        oe_n;
   logic [4:0]  row_addr;
   logic        underflow;
`ifdef LED_SCHED_UNDERFLOW_CNT_EN
   logic [15:0] underflow_cnt;

   modport master (
      input  en, fifo_dout, fifo_valid, pix_ready,
      output fifo_re, pix_data, pix_valid, line_start, latch, oe_n, row_addr, underflow,
      output underflow_cnt
   );
   modport slave (
      output en, fifo_dout, fifo_valid, pix_ready,
      input  fifo_re, pix_data, pix_valid, line_start, latch, oe_n, row_addr, underflow,
      input  underflow_cnt
   );
`else
   modport master (
      input  en, fifo_dout, fifo_valid, pix_ready,
      output fifo_re, pix_data, pix_valid, line_start, latch, oe_n, row_addr, underflow
   );
   modport slave (
      output en, fifo_dout, fifo_valid, pix_ready,
      input  fifo_re, pix_data, pix_valid, line_start, latch, oe_n, row_addr, underflow
   );
`endif
endinterface

// File: rtl/led_line_sched.sv
// LED panel scan-line scheduler: streams one line of FIFO words to the column shifter, then latches and blanks.
// Define LED_SCHED_UNDERFLOW_CNT_EN to add the saturating underflow_cnt status counter.
module led_line_sched #(
   parameter int WORDS_PER_LINE = 64,
   parameter int ROWS           = 16,
   parameter int LATCH_CYC      = 2,
   parameter int BLANK_CYC      = 4
) (
   input  logic             clkr,
   input  logic             rst,
   led_line_sched_if.master sched
);
   localparam int CW   = $clog2(WORDS_PER_LINE);
   localparam int TMAX = (LATCH_CYC > BLANK_CYC) ? LATCH_CYC : BLANK_CYC;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [CW-1:0] LAST_WORD  = CW'(WORDS_PER_LINE - 1);
   localparam logic [TW-1:0] LATCH_LAST = TW'(LATCH_CYC - 1);
   localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
   localparam logic [4:0]    ROW_LAST   = 5'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, BLANK} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [TW-1:0] tmr_q;
   logic [4:0]    row_q;
   logic          latched_q;
   logic          starve_q;

   logic in_shift, xfer, starve;

   // Pixel path is a zero-latency pass-through of the FIFO head while shifting.
   assign in_shift         = (state_q == SHIFT);
   assign sched.pix_data   = sched.fifo_dout;
   assign sched.pix_valid  = in_shift & sched.fifo_valid;
   assign xfer             = sched.pix_valid & sched.pix_ready;
   assign sched.fifo_re    = xfer;
   assign sched.line_start = xfer & (cnt_q == '0);

   // Starvation only counts once the line has started; pulse on the first starved cycle.
   assign starve          = in_shift & (cnt_q != '0) & ~sched.fifo_valid;
   assign sched.underflow = starve & ~starve_q;

   assign sched.latch    = (state_q == LATCH);
   assign sched.oe_n     = (state_q == LATCH) | (state_q == BLANK) | ~latched_q;
   assign sched.row_addr = row_q;

   always_ff @(posedge clkr or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         tmr_q     <= '0;
         row_q     <= '0;
         latched_q <= 1'b0;
         starve_q  <= 1'b0;
      end else begin
         starve_q <= starve;
         case (state_q)
            IDLE: begin
               if (sched.en && sched.fifo_valid) begin
                  state_q <= SHIFT;
                  cnt_q   <= '0;
               end
            end
            SHIFT: begin
               if (xfer) begin
                  if (cnt_q == LAST_WORD) begin
                     state_q <= LATCH;
                     cnt_q   <= '0;
                     tmr_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            LATCH: begin
               if (tmr_q == LATCH_LAST) begin
                  state_q   <= BLANK;
                  tmr_q     <= '0;
                  latched_q <= 1'b1;
                  row_q     <= (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            BLANK: begin
               if (tmr_q == BLANK_LAST) state_q <= IDLE;
               else                     tmr_q   <= tmr_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef LED_SCHED_UNDERFLOW_CNT_EN
   logic [15:0] ucnt_q;

   always_ff @(posedge clkr or posedge rst) begin
      if (rst)                                        ucnt_q <= '0;
      else if (sched.underflow && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
   end

   assign sched.underflow_cnt = ucnt_q;
`endif
endmodule
